uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: the far-end counterpart of uart_tx (8N1, LSB first, idle-high line).
- Replaces fixed one-tick-per-bit sampling with start-edge-aligned mid-bit sampling, glitch rejection, framing-error detection and a ready/valid output with overrun reporting.
- Generates its own oversample tick from the system clock.
- Instantiated alongside uart_tx in the UART top level, with rx driven straight from the pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- OVERSAMPLE, 16, ticks per bit period. Must be an even number >= 8.
- Derived constant, not overridable: DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), truncated; DIV >= 2 is required. Default DIV = 651.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line input.
- rx_data  output  8  last received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held high until accepted.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
- overrun  output  1  one-cycle pulse: an unaccepted byte was overwritten.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - Both synchronizer flops=1; FSM=IDLE; all counters=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte is ever presented.
- Input path: 2-flop synchronizer, giving rxs. Edge detection compares rxs with its previous value.
- Tick generator:
  - div_cnt counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - It is held at 0 in IDLE, so tick phase aligns to the detected start edge.
- os_cnt counts ticks 0..OVERSAMPLE-1 and wraps to 0.
- FSM:
  - IDLE: on a falling edge of rxs, clear div_cnt/os_cnt and go to START.
  - START: at tick with os_cnt = OVERSAMPLE/2-1 (mid start bit):
    - if rxs=0, clear os_cnt, clear bit_cnt, go to DATA;
    - if rxs=1, treat as a glitch and return to IDLE with no flags.
  - DATA: at each tick with os_cnt = OVERSAMPLE-1 (mid bit):
    - shift rxs into the MSB of the shift register (LSB received first);
    - bit_cnt increments; after the 8th sample go to STOP.
  - STOP: at the mid-stop sample:
    - if rxs=1, load rx_data from the shift register, set rx_valid the next cycle, go to IDLE;
    - if rxs=0, pulse frame_err, discard the byte (rx_data and rx_valid unchanged), go to IDLE.
  - Returning to IDLE at mid-stop lets back-to-back frames be received with a 1-stop-bit gap.
- Output handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready.
  - New byte completes while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, overrun pulses for one cycle.
  - Completion coincides with rx_valid && rx_ready: the new byte loads, rx_valid stays 1, no overrun.
- Latency: from the synchronized start edge to rx_valid is 9.5 bit periods + 1 clock. The 2-flop synchronizer adds 2 more clocks from the pin.
- frame_err and overrun never assert in the same cycle. A frame error never touches the output register.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving DIV=10 and a bit period of 160 clocks.
1. Drive 8N1 frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1), rx_ready=0 -> rx_valid rises about 1523 clocks after the falling edge; rx_data=0xA5; frame_err=0; busy low after mid-stop; rx_valid holds until rx_ready=1, then clears the next cycle.
2. Pulse rx low for 40 clocks, then high -> FSM returns to IDLE at mid-start (about 80 clocks); no rx_valid, frame_err or overrun; busy drops.
3. Frame 0x3C with stop bit driven 0 -> single-cycle frame_err at mid-stop; rx_valid stays 0; rx_data keeps its previous value.
4. Back-to-back 0x01 then 0x02, rx_ready held 0 -> after the first frame rx_data=0x01; at the second completion, one-cycle overrun pulse, rx_data=0x02, rx_valid still 1.
5. Byte 0x11 pending; assert rx_ready exactly in the completion cycle of byte 0x22 -> rx_data=0x22, rx_valid=1, overrun=0.
6. Assert rst for 3 clocks after the 4th data bit of a frame -> all outputs at reset values immediately; the line then idles and frame 0x5A is received with rx_data=0x5A and no error flags.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1 UART receiver with mid-bit sampling,
// glitch rejection, framing-error detection and ready/valid output.
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = $clog2(DIV);
  localparam int OW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic          rxs_q;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          fall;
  logic          os_wrap;

  assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
  assign fall    = rxs_q && !rxs;
  assign os_wrap = (os_cnt == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      // Counters idle at zero so tick phase follows the start edge
      if (state == IDLE) begin
        div_cnt <= '0;
        os_cnt  <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)
          os_cnt <= os_wrap ? '0 : os_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick && os_cnt == OS_MID) begin
            if (!rxs) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick && os_wrap) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          // Leave at mid-stop so a following start edge is not missed
          if (tick && os_wrap) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ready;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os with DIV=10,
// 160 clocks per bit; checks latency, flags and handshake.
module tb_uart_rx_os;

  localparam int BIT = 160;
  localparam int LAT = 1523;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;
  int ov_cnt = 0;
  logic busy_rise = 1'b0;
  logic v_d = 1'b0;

  int r0, f0, e0, o0;

  uart_rx_os #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_valid && !v_d) begin
      rise_cyc  = cyc;
      rise_cnt++;
      busy_rise = busy;
    end
    if (!rx_valid && v_d)
      fall_cnt++;
    v_d = rx_valid;
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun)
      ov_cnt++;
  end

  task automatic chk(input logic [31:0] obs,
                     input logic [31:0] exp,
                     input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = bits[i];
      if (i == 0)
        start_cyc = cyc;
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic snap();
    r0 = rise_cnt;
    f0 = fall_cnt;
    e0 = fe_cnt;
    o0 = ov_cnt;
  endtask

  initial begin
    #1;
    chk(rx_data, 8'h00, "rst_data");
    chk(rx_valid, 1'b0, "rst_valid");
    chk(frame_err, 1'b0, "rst_ferr");
    chk(overrun, 1'b0, "rst_ovr");
    chk(busy, 1'b0, "rst_busy");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: plain frame, held until accepted
    snap();
    send_frame(8'hA5, 1'b1);
    chk(rise_cnt, r0 + 1, "t1_rise");
    chk(rise_cyc - start_cyc, LAT, "t1_latency");
    chk(rx_data, 8'hA5, "t1_data");
    chk(fe_cnt, e0, "t1_ferr");
    chk(busy_rise, 1'b0, "t1_busy_at_valid");
    repeat (20) @(negedge clk);
    chk(rx_valid, 1'b1, "t1_hold");
    rx_ready = 1'b1;
    @(negedge clk);
    chk(rx_valid, 1'b0, "t1_accept");
    rx_ready = 1'b0;
    repeat (20) @(negedge clk);

    // 2: short low glitch
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk(busy, 1'b1, "t2_busy_hi");
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk(busy, 1'b0, "t2_busy_lo");
    chk(rise_cnt, r0, "t2_no_valid");
    chk(fe_cnt, e0, "t2_no_ferr");
    chk(ov_cnt, o0, "t2_no_ovr");

    // 3: stop bit low
    snap();
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk(fe_cnt, e0 + 1, "t3_ferr_once");
    chk(fe_cyc - start_cyc, LAT, "t3_ferr_time");
    chk(rx_valid, 1'b0, "t3_valid");
    chk(rx_data, 8'hA5, "t3_data_kept");
    chk(ov_cnt, o0, "t3_no_ovr");

    // 4: back-to-back with consumer stalled
    snap();
    send_frame(8'h01, 1'b1);
    chk(rx_data, 8'h01, "t4_data1");
    chk(rx_valid, 1'b1, "t4_valid1");
    chk(ov_cnt, o0, "t4_no_ovr1");
    send_frame(8'h02, 1'b1);
    chk(ov_cnt, o0 + 1, "t4_ovr_once");
    chk(rx_data, 8'h02, "t4_data2");
    chk(rx_valid, 1'b1, "t4_valid2");
    chk(fe_cnt, e0, "t4_no_ferr");
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk(rx_valid, 1'b0, "t4_accept");
    repeat (20) @(negedge clk);

    // 5: accept coincides with completion
    snap();
    send_frame(8'h11, 1'b1);
    chk(rx_data, 8'h11, "t5_data1");
    repeat (10) @(negedge clk);
    snap();
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk(rx_data, 8'h22, "t5_data2");
        chk(rx_valid, 1'b1, "t5_valid");
        chk(overrun, 1'b0, "t5_ovr_pin");
      end
    join
    chk(ov_cnt, o0, "t5_no_ovr");
    chk(fall_cnt, f0, "t5_valid_no_gap");
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk(rx_valid, 1'b0, "t5_accept");
    repeat (20) @(negedge clk);

    // 6: reset after the 4th data bit of 0x77
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 3);
      repeat (BIT) @(negedge clk);
    end
    chk(busy, 1'b1, "t6_busy_mid");
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk(rx_data, 8'h00, "t6_rst_data");
    chk(rx_valid, 1'b0, "t6_rst_valid");
    chk(busy, 1'b0, "t6_rst_busy");
    chk(frame_err, 1'b0, "t6_rst_ferr");
    chk(overrun, 1'b0, "t6_rst_ovr");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk(rise_cnt, r0, "t6_no_partial");
    chk(busy, 1'b0, "t6_idle");
    send_frame(8'h5A, 1'b1);
    chk(rx_data, 8'h5A, "t6_data");
    chk(rx_valid, 1'b1, "t6_valid");
    chk(rise_cyc - start_cyc, LAT, "t6_latency");
    chk(fe_cnt, e0, "t6_no_ferr");
    chk(ov_cnt, o0, "t6_no_ovr");

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
